// File: rtl/hx8352_pkg.sv
// hx8352_pkg: shared cmd codes, ROM word field positions and sequencer state encoding
package hx8352_pkg;
    localparam logic [7:0] CMD_Custom_Delay = 8'hFE;
    localparam logic [7:0] CMD_Custom_Done  = 8'hFF;
    localparam int ROM_CMD_MSB  = 23;
    localparam int ROM_CMD_LSB  = 16;
    localparam int ROM_DATA_MSB = 15;
    localparam int ROM_DATA_LSB = 0;
    typedef enum logic [3:0] {
        S_IDLE, S_RST_LO, S_RST_WAIT, S_FETCH, S_DECODE,
        S_WRITE, S_DELAY, S_ADVANCE, S_DONE
    } state_t;
endpackage

// File: rtl/hx8352_init_seq_if.sv
// hx8352_init_seq_if: ROM read port and bus-writer request channel of the init sequencer
//   rom_addr/rom_data : registered address out, ROM word back one cycle later
//   wr_valid/wr_ready : request handshake, wr_cmd/wr_data held while pending
//   master = sequencer side, slave = ROM + bus writer side
interface hx8352_init_seq_if;
    logic [7:0]  rom_addr;
    logic [31:0] rom_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  wr_cmd;
    logic [15:0] wr_data;
    modport master (output rom_addr, wr_valid, wr_cmd, wr_data, input rom_data, wr_ready);
    modport slave  (input rom_addr, wr_valid, wr_cmd, wr_data, output rom_data, wr_ready);
endinterface

// File: rtl/hx8352_us_tick.sv
// hx8352_us_tick: free-running microsecond prescaler
//   clk, rst_n : clock, async active-low reset
//   i_clr      : restart the prescaler period (counter back to 0 next cycle)
//   o_tick     : high for one cycle at the end of every US_DIV-cycle period
module hx8352_us_tick #(
    parameter int US_DIV = 50
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    output logic o_tick
);
    localparam int CW = $clog2(US_DIV);
    localparam logic [CW-1:0] LAST = CW'(US_DIV - 1);
    logic [CW-1:0] r_cnt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_cnt <= '0;
        else        r_cnt <= (i_clr || r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    // Not gated by i_clr: the clear is derived from the next state, which itself depends on this tick.
    assign o_tick = r_cnt == LAST;
endmodule

// File: rtl/hx8352_init_seq.sv
// hx8352_init_seq: HX8352 power-up sequencer (panel reset pulse, then init ROM walk)
//   clk, rst_n  : clock, async active-low reset
//   i_start     : one-cycle pulse, starts a sequence from IDLE or DONE
//   bus         : ROM read port and write request channel (master side)
//   o_lcd_rst_n : panel hardware reset
//   o_busy      : sequence in progress
//   o_done      : sequence finished
//   o_err       : ROM exhausted without an end marker
module hx8352_init_seq
    import hx8352_pkg::*;
#(
    parameter int CLK_FREQ_HZ   = 50_000_000,
    parameter int ROM_DEPTH     = 52,
    parameter int RESET_LOW_US  = 20,
    parameter int RESET_WAIT_US = 120_000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_start,
    hx8352_init_seq_if.master        bus,
    output logic                     o_lcd_rst_n,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_err
);
    localparam int US_DIV = CLK_FREQ_HZ / 1_000_000;
    localparam logic [7:0] LAST_ADDR = 8'(ROM_DEPTH - 1);

    state_t      r_state, w_next;
    logic [7:0]  r_addr;
    logic        r_valid;
    logic [7:0]  r_cmd;
    logic [15:0] r_data;
    logic        r_err;
    logic [16:0] r_dly;
    logic        w_tick, w_enter, w_expire;
    logic [7:0]  w_cmd;
    logic [15:0] w_dat;

    assign w_cmd    = bus.rom_data[ROM_CMD_MSB:ROM_CMD_LSB];
    assign w_dat    = bus.rom_data[ROM_DATA_MSB:ROM_DATA_LSB];
    // The counter is loaded with N >= 1 on entry and steps once per tick, so the state lasts N*US_DIV cycles.
    assign w_expire = w_tick && r_dly == 17'd1;

    hx8352_us_tick #(.US_DIV(US_DIV)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_enter),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (i_start) w_next = S_RST_LO;
            S_RST_LO:       if (w_expire) w_next = S_RST_WAIT;
            S_RST_WAIT:     if (w_expire) w_next = S_FETCH;
            S_FETCH:        w_next = S_DECODE;
            S_DECODE:       w_next = w_cmd == CMD_Custom_Done  ? S_DONE :
                                     w_cmd == CMD_Custom_Delay ? (w_dat == 16'd0 ? S_ADVANCE : S_DELAY) :
                                     S_WRITE;
            S_WRITE:        if (r_valid && bus.wr_ready) w_next = S_ADVANCE;
            S_DELAY:        if (w_expire) w_next = S_ADVANCE;
            S_ADVANCE:      w_next = r_addr == LAST_ADDR ? S_DONE : S_FETCH;
            default:        w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_lcd_rst_n = r_state != S_RST_LO;
        o_busy      = !(r_state == S_IDLE || r_state == S_DONE);
        o_done      = r_state == S_DONE;
        w_enter     = w_next != r_state && w_next inside {S_RST_LO, S_RST_WAIT, S_DELAY};
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_addr  <= '0;
            r_valid <= 1'b0;
            r_cmd   <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
            r_dly   <= '0;
        end else begin
            if (w_enter)
                r_dly <= w_next == S_RST_LO   ? 17'(RESET_LOW_US)  :
                         w_next == S_RST_WAIT ? 17'(RESET_WAIT_US) : {1'b0, w_dat};
            else if (w_tick && r_dly != 17'd0)
                r_dly <= r_dly - 1'b1;
            if (r_state == S_RST_WAIT)
                r_addr <= '0;
            else if (r_state == S_ADVANCE && r_addr != LAST_ADDR)
                r_addr <= r_addr + 1'b1;
            if (r_state == S_DECODE && w_next == S_WRITE) begin
                r_valid <= 1'b1;
                r_cmd   <= w_cmd;
                r_data  <= w_dat;
            end else if (r_state == S_WRITE && bus.wr_ready)
                r_valid <= 1'b0;
            if (r_state == S_ADVANCE && r_addr == LAST_ADDR)
                r_err <= 1'b1;
            else if (w_enter && w_next == S_RST_LO)
                r_err <= 1'b0;
        end

    assign bus.rom_addr = r_addr;
    assign bus.wr_valid = r_valid;
    assign bus.wr_cmd   = r_cmd;
    assign bus.wr_data  = r_data;
    assign o_err        = r_err;
endmodule

// File: tb/tb_hx8352_init_seq.sv
// tb_hx8352_init_seq: scoreboard bench for the HX8352 init sequencer with a model ROM and bus writer
module tb_hx8352_init_seq;
    localparam int CLK_HZ  = 10_000_000;
    localparam int DIV     = 10;
    localparam int LOW_US  = 2;
    localparam int WAIT_US = 3;
    localparam int DEPTH   = 4;
    localparam int BOUND   = 20000;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, ready = 1'b1;
    logic lcd_rst_n, busy, done, err;
    logic [31:0] rom [DEPTH];

    int n_tests = 0, n_fail = 0, cyc = 0;
    int n_wr = 0, n_stall = 0, last_acc = 0, prev_acc = 0;
    logic [23:0] exp_q [$];
    logic p_stall = 1'b0;
    logic [23:0] p_wr = '0;

    always #5 clk = ~clk;

    hx8352_init_seq_if bus();

    hx8352_init_seq #(
        .CLK_FREQ_HZ   (CLK_HZ),
        .ROM_DEPTH     (DEPTH),
        .RESET_LOW_US  (LOW_US),
        .RESET_WAIT_US (WAIT_US)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (start),
        .bus         (bus),
        .o_lcd_rst_n (lcd_rst_n),
        .o_busy      (busy),
        .o_done      (done),
        .o_err       (err)
    );

    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr[1:0]];
    assign bus.wr_ready = ready;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bus writer side: pop the scoreboard on each handshake, and require a pending request to stay put.
    always @(negedge clk) begin
        if (!rst_n) begin
            p_stall <= 1'b0;
        end else begin
            if (p_stall) begin
                check("hold_valid", {31'd0, bus.wr_valid}, 32'd1);
                check("hold_word", {8'd0, bus.wr_cmd, bus.wr_data}, {8'd0, p_wr});
            end
            if (bus.wr_valid && bus.wr_ready) begin
                check("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0)
                    check("wr_word", {8'd0, bus.wr_cmd, bus.wr_data}, {8'd0, exp_q.pop_front()});
                n_wr     <= n_wr + 1;
                prev_acc <= last_acc;
                last_acc <= cyc;
            end
            if (bus.wr_valid && !bus.wr_ready) n_stall <= n_stall + 1;
            p_stall <= bus.wr_valid && !bus.wr_ready;
            p_wr    <= {bus.wr_cmd, bus.wr_data};
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic reset_phase(input string tag, output int rise);
        int n = 0;
        check({tag, "_lcd_lo"}, {31'd0, lcd_rst_n}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        while (!lcd_rst_n && n < BOUND) begin
            step();
            n++;
        end
        check({tag, "_lo_cycles"}, n, LOW_US * DIV);
        rise = cyc;
    endtask

    task automatic wait_valid(input string tag, output int at);
        int n = 0;
        while (!bus.wr_valid && n < BOUND) begin
            step();
            n++;
        end
        check({tag, "_valid_timeout"}, {31'd0, n < BOUND}, 32'd1);
        at = cyc;
    endtask

    task automatic wait_done(input string tag, output int at);
        int n = 0;
        while (!done && n < BOUND) begin
            step();
            n++;
        end
        check({tag, "_done_timeout"}, {31'd0, n < BOUND}, 32'd1);
        at = cyc;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_addr"}, {24'd0, bus.rom_addr}, 32'd0);
        check({tag, "_valid"}, {31'd0, bus.wr_valid}, 32'd0);
        check({tag, "_cmd"}, {24'd0, bus.wr_cmd}, 32'd0);
        check({tag, "_data"}, {16'd0, bus.wr_data}, 32'd0);
        check({tag, "_lcd"}, {31'd0, lcd_rst_n}, 32'd1);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int rise, at, t, wr0, st0;
        rom = '{32'h0, 32'h0, 32'h0, 32'h0};
        step(2);
        check_reset_values("rst");
        rst_n = 1'b1;
        step(2);
        check_reset_values("idle");

        // Two writes then end marker
        rom = '{32'h0083_0002, 32'h0085_0003, 32'h00FF_0000, 32'h0};
        exp_q.push_back(24'h83_0002);
        exp_q.push_back(24'h85_0003);
        wr0 = n_wr;
        pulse_start();
        reset_phase("s1", rise);
        wait_valid("s1", at);
        check("s1_first_wr", at - rise, WAIT_US * DIV + 2);
        wait_done("s1", t);
        check("s1_wr_gap", last_acc - prev_acc, 4);
        check("s1_done_lat", t - last_acc, 4);
        check("s1_n_wr", n_wr - wr0, 2);
        check("s1_done", {31'd0, done}, 32'd1);
        check("s1_err", {31'd0, err}, 32'd0);
        check("s1_busy", {31'd0, busy}, 32'd0);
        check("s1_sb_empty", exp_q.size(), 0);

        // 5 us delay before a write
        rom = '{32'h00FE_0005, 32'h0016_001C, 32'h00FF_0000, 32'h0};
        exp_q.push_back(24'h16_001C);
        wr0 = n_wr;
        pulse_start();
        reset_phase("s2", rise);
        wait_valid("s2", at);
        check("s2_delay_wr", at - rise, WAIT_US * DIV + 2 + 5 * DIV + 3);
        wait_done("s2", t);
        check("s2_n_wr", n_wr - wr0, 1);
        check("s2_err", {31'd0, err}, 32'd0);
        check("s2_sb_empty", exp_q.size(), 0);

        // Writer stalls the first request for 7 cycles
        ready = 1'b0;
        rom = '{32'h0083_0002, 32'h0085_0003, 32'h00FF_0000, 32'h0};
        exp_q.push_back(24'h83_0002);
        exp_q.push_back(24'h85_0003);
        wr0 = n_wr;
        st0 = n_stall;
        pulse_start();
        reset_phase("s3", rise);
        wait_valid("s3", at);
        step(7);
        ready = 1'b1;
        wait_done("s3", t);
        check("s3_stall_cycles", n_stall - st0, 7);
        check("s3_n_wr", n_wr - wr0, 2);
        check("s3_sb_empty", exp_q.size(), 0);

        // No end marker: ROM runs out
        rom = '{32'h0011_0001, 32'h0022_0002, 32'h0033_0003, 32'h0044_0004};
        exp_q.push_back(24'h11_0001);
        exp_q.push_back(24'h22_0002);
        exp_q.push_back(24'h33_0003);
        exp_q.push_back(24'h44_0004);
        wr0 = n_wr;
        pulse_start();
        reset_phase("s4", rise);
        wait_done("s4", t);
        check("s4_n_wr", n_wr - wr0, 4);
        check("s4_done", {31'd0, done}, 32'd1);
        check("s4_err", {31'd0, err}, 32'd1);
        check("s4_addr", {24'd0, bus.rom_addr}, 32'd3);
        check("s4_sb_empty", exp_q.size(), 0);

        // Restart from DONE clears done/err; pulses while busy are ignored
        rom = '{32'h0083_0002, 32'h00FF_0000, 32'h0, 32'h0};
        exp_q.push_back(24'h83_0002);
        wr0 = n_wr;
        pulse_start();
        check("s6_done_clr", {31'd0, done}, 32'd0);
        check("s6_err_clr", {31'd0, err}, 32'd0);
        reset_phase("s6", rise);
        step(5);
        pulse_start();
        check("s6_ign_wait", {31'd0, lcd_rst_n}, 32'd1);
        wait_valid("s6", at);
        pulse_start();
        check("s6_ign_write", {31'd0, lcd_rst_n}, 32'd1);
        wait_done("s6", t);
        check("s6_n_wr", n_wr - wr0, 1);
        check("s6_err", {31'd0, err}, 32'd0);
        check("s6_sb_empty", exp_q.size(), 0);

        // Async reset in the middle of a 1000 us delay, then replay
        rom = '{32'h00FE_03E8, 32'h00FF_0000, 32'h0, 32'h0};
        pulse_start();
        reset_phase("s5", rise);
        step(40);
        check("s5_in_delay", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_values("s5_async");
        step(2);
        rst_n = 1'b1;
        step(2);
        rom = '{32'h0083_0002, 32'h00FF_0000, 32'h0, 32'h0};
        exp_q.push_back(24'h83_0002);
        wr0 = n_wr;
        pulse_start();
        reset_phase("s5r", rise);
        check("s5r_addr", {24'd0, bus.rom_addr}, 32'd0);
        wait_valid("s5r", at);
        check("s5r_first_wr", at - rise, WAIT_US * DIV + 2);
        wait_done("s5r", t);
        check("s5r_n_wr", n_wr - wr0, 1);
        check("s5r_sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
